cmd_master: RTL

- Host-side initiator for the UART command protocol; used for board-to-board and loopback self-test of the command dispatcher.
- On `start` it transmits one command byte through `uart_tx`, optionally followed by one argument byte.
- It then collects a fixed number of reply bytes from `uart_rx`, with an inter-byte timeout and a running modulo-256 checksum.
- It sits between a test sequencer (or seven-segment/LED debug logic) and the `uart_tx`/`uart_rx` instances.

---
 rtl/cmd_master_if.sv | 42 ++++
 rtl/cmd_master.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cmd_master_if.sv
// Host-side and UART-side signal bundle for cmd_master.
// The arg/arg_en pair exists only when CMD_MASTER_ARG_EN is defined.
interface cmd_master_if;
  logic       start;
  logic [7:0] cmd;
  logic [7:0] reply_len;
`ifdef CMD_MASTER_ARG_EN
  logic [7:0] arg;
  logic       arg_en;
`endif
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_active;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] reply_byte;
  logic       reply_valid;
  logic [7:0] reply_cnt;
  logic [7:0] checksum;

  modport master (
`ifdef CMD_MASTER_ARG_EN
    input  arg, arg_en,
`endif
    input  start, cmd, reply_len, tx_active, tx_done, rx_data, rx_ready,
    output busy, done, timeout_err, tx_data, tx_start,
    output reply_byte, reply_valid, reply_cnt, checksum
  );

  modport slave (
`ifdef CMD_MASTER_ARG_EN
    output arg, arg_en,
`endif
    output start, cmd, reply_len, tx_active, tx_done, rx_data, rx_ready,
    input  busy, done, timeout_err, tx_data, tx_start,
    input  reply_byte, reply_valid, reply_cnt, checksum
  );
endinterface

// File: rtl/cmd_master.sv
// UART command initiator: sends cmd (then arg when CMD_MASTER_ARG_EN is defined
// and arg_en was latched), then collects reply_len bytes with timeout and checksum.
module cmd_master #(
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int TO_W           = 23
) (
  input  logic         clk_50mhz,
  input  logic         reset,
  cmd_master_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TX_WAIT = 3'd1;
  localparam logic [2:0] S_TX_SEND = 3'd2;
  localparam logic [2:0] S_RX      = 3'd3;
  localparam logic [2:0] S_FIN     = 3'd4;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]      r_state;
  logic [7:0]      r_cmd;
  logic [7:0]      r_len;
  logic [TO_W-1:0] r_timer;
  logic            r_rx_q1;
  logic            r_rx_q2;
  logic            r_busy;
  logic            r_done;
  logic            r_timeout_err;
  logic            r_tx_start;
  logic [7:0]      r_tx_data;
  logic [7:0]      r_reply_byte;
  logic            r_reply_valid;
  logic [7:0]      r_reply_cnt;
  logic [7:0]      r_checksum;

  logic            w_rx_edge;
  logic [7:0]      w_cnt_next;
  logic [7:0]      w_tx_byte;
  logic            w_more_tx;

`ifdef CMD_MASTER_ARG_EN
  logic [7:0] r_arg;
  logic       r_arg_en;
  logic       r_arg_phase;

  assign w_tx_byte = r_arg_phase ? r_arg : r_cmd;
  assign w_more_tx = r_arg_en & ~r_arg_phase;
`else
  assign w_tx_byte = r_cmd;
  assign w_more_tx = 1'b0;
`endif

  // A held rx_ready level yields a single one-cycle edge.
  assign w_rx_edge  = r_rx_q1 & ~r_rx_q2;
  assign w_cnt_next = r_reply_cnt + 8'd1;

  // NOTE: every register here uses <= so all reads see pre-edge values;
  // blocking assignments would make the FSM order-dependent.
  always_ff @(posedge clk_50mhz) begin
    // NOTE: reset is synchronous and clears every register, including the
    // latched command, so a reset cycle leaves no stale transaction behind.
    if (reset) begin
      r_state       <= S_IDLE;
      r_cmd         <= 8'h00;
      r_len         <= 8'h00;
      r_timer       <= '0;
      r_rx_q1       <= 1'b0;
      r_rx_q2       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_reply_byte  <= 8'h00;
      r_reply_valid <= 1'b0;
      r_reply_cnt   <= 8'h00;
      r_checksum    <= 8'h00;
`ifdef CMD_MASTER_ARG_EN
      r_arg         <= 8'h00;
      r_arg_en      <= 1'b0;
      r_arg_phase   <= 1'b0;
`endif
    end else begin
      r_rx_q1       <= bus.rx_ready;
      r_rx_q2       <= r_rx_q1;
      r_done        <= 1'b0;
      r_reply_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cmd         <= bus.cmd;
            r_len         <= bus.reply_len;
            r_reply_cnt   <= 8'h00;
            r_checksum    <= 8'h00;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= S_TX_WAIT;
`ifdef CMD_MASTER_ARG_EN
            r_arg         <= bus.arg;
            r_arg_en      <= bus.arg_en;
            r_arg_phase   <= 1'b0;
`endif
          end
        end

        S_TX_WAIT: begin
          if (!bus.tx_active) begin
            r_tx_data  <= w_tx_byte;
            r_tx_start <= 1'b1;
            r_state    <= S_TX_SEND;
          end
        end

        S_TX_SEND: begin
          if (bus.tx_active || bus.tx_done) r_tx_start <= 1'b0;
          if (bus.tx_done) begin
            if (w_more_tx) begin
              r_state <= S_TX_WAIT;
`ifdef CMD_MASTER_ARG_EN
              r_arg_phase <= 1'b1;
`endif
            end else if (r_len != 8'h00) begin
              r_timer <= '0;
              r_state <= S_RX;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end

        S_RX: begin
          // A byte arriving on the terminal-count cycle takes priority.
          if (w_rx_edge) begin
            r_reply_byte  <= bus.rx_data;
            r_reply_valid <= 1'b1;
            r_reply_cnt   <= w_cnt_next;
            r_checksum    <= r_checksum + bus.rx_data;
            r_timer       <= '0;
            if (w_cnt_next == r_len) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end else if (r_timer == TO_LAST) begin
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_state       <= S_FIN;
          end else begin
            r_timer <= r_timer + TO_W'(1);
          end
        end

        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.timeout_err = r_timeout_err;
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_start    = r_tx_start;
  assign bus.reply_byte  = r_reply_byte;
  assign bus.reply_valid = r_reply_valid;
  assign bus.reply_cnt   = r_reply_cnt;
  assign bus.checksum    = r_checksum;

endmodule
